serial_subtractor_16_bit: RTL and testbench

- Bit-serial two's-complement subtractor: computes DIFF = A - B, LSB first, one bit per clock, using a single full-adder cell.
- Serves as the area-cheap sequential counterpart to the combinational 16-bit ripple adder/subtractor.
- Uses a start/busy/done handshake.
- Results are held stable until the next operation completes.

---
 rtl/serial_arith_pkg.sv | 28 ++
 rtl/full_adder_1bit.sv | 19 +
 rtl/serial_subtractor_16_bit.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor_16_bit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared constants, FSM state encoding and sizing helper for
//                the bit-serial arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

   // Default operand/result width of the serial subtractor
   localparam int C_DEFAULT_WIDTH = 16;

   // Two-state controller: waiting for a request, or shifting bits through
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit counter width needed to count 0..w-1 (never narrower than one bit)
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   // Counter width for the default configuration
   localparam int C_DEFAULT_CNT_W = cnt_width(C_DEFAULT_WIDTH);

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_adder_1bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_1bit
//  Description : Single-bit full adder cell (sum and majority carry).
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit
`default_nettype wire

// File: rtl/serial_subtractor_16_bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_16_bit
//  Description : Bit-serial two's-complement subtractor. Computes a - b LSB
//                first, one bit per clock through a single full-adder cell,
//                behind a start/busy/done handshake. Results are held until
//                the next operation completes.
//                Optional build macro SERIAL_SUB_ADD_MODE_EN adds a 'mode'
//                input (0 = subtract, 1 = add) sampled together with start.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_16_bit
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
   input  logic             mode,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int              CNT_W  = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   // Controller and serial datapath state
   state_t              r_state;
   logic [WIDTH-1:0]    r_sa;
   logic [WIDTH-1:0]    r_sb;
   logic [WIDTH-2:0]    r_res;      // result bits produced so far (MSB-aligned)
   logic [CNT_W-1:0]    r_cnt;
   logic                r_carry;
   logic                r_a_msb;    // captured sign bits for overflow detection
   logic                r_b_msb;

   // Registered outputs
   logic                r_busy;
   logic                r_done;
   logic [WIDTH-1:0]    r_diff;
   logic                r_borrow;
   logic                r_ovf;

   // Datapath wires
   logic                w_b_op;     // subtrahend bit as presented to the adder
   logic                w_cin0;     // carry seed on capture
   logic                w_s;
   logic                w_cout;
   logic [WIDTH-1:0]    w_res_nxt;  // result register after inserting this bit
   logic                w_borrow_nxt;
   logic                w_ovf_nxt;

`ifdef SERIAL_SUB_ADD_MODE_EN
   logic                r_mode;

   // Add mode feeds b straight through with a zero carry seed and reports
   // the raw carry; subtract mode computes a + ~b + 1 and reports ~carry.
   assign w_cin0       = ~mode;
   assign w_b_op       = r_mode ? r_sb[0] : ~r_sb[0];
   assign w_borrow_nxt = r_mode ? w_cout  : ~w_cout;
   assign w_ovf_nxt    = (r_mode ? (r_a_msb == r_b_msb) : (r_a_msb != r_b_msb))
                         && (w_s != r_a_msb);
`else
   // Subtract as a + ~b + 1: invert b outside the adder, seed the carry with 1
   assign w_cin0       = 1'b1;
   assign w_b_op       = ~r_sb[0];
   assign w_borrow_nxt = ~w_cout;
   assign w_ovf_nxt    = (r_a_msb != r_b_msb) && (w_s != r_a_msb);
`endif

   // The one and only adder cell; it sees the current LSBs of both operands
   full_adder_1bit u_fa (
      .a    (r_sa[0]),
      .b    (w_b_op),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   // New sum bit enters at the top; on the final step this is the full result
   assign w_res_nxt = {w_s, r_res};

   // Controller, shift registers and held result/flag outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
         r_mode   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // The done cycle is an IDLE cycle, so back-to-back starts work
               if (start) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_a_msb <= a[WIDTH-1];
                  r_b_msb <= b[WIDTH-1];
                  r_carry <= w_cin0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
`ifdef SERIAL_SUB_ADD_MODE_EN
                  r_mode  <= mode;
`endif
               end
            end

            RUN: begin
               r_carry <= w_cout;
               r_res   <= w_res_nxt[WIDTH-1:1];
               r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
               r_cnt   <= r_cnt + CNT_W'(1);
               // Last bit: publish result and flags together, never partials
               if (r_cnt == C_LAST) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_diff   <= w_res_nxt;
                  r_borrow <= w_borrow_nxt;
                  r_ovf    <= w_ovf_nxt;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign ovf    = r_ovf;

endmodule : serial_subtractor_16_bit
`default_nettype wire

// File: tb/tb_serial_subtractor_16_bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_16_bit
//  Description : Directed self-checking bench for serial_subtractor_16_bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_16_bit;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
`ifdef SERIAL_SUB_ADD_MODE_EN
   logic             mode;
`endif
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;

   int n_chk  = 0;
   int n_pass = 0;

   serial_subtractor_16_bit #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
`ifdef SERIAL_SUB_ADD_MODE_EN
      .mode   (mode),
`endif
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Count busy samples (negedges) until busy drops, then expect the done pulse
   task automatic wait_done(input string tag, input int exp_n);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, n, exp_n);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
   endtask

   // Start one operation and check the results in the done cycle
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_d, input logic exp_b, input logic exp_o);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(tag, 16);
      check({tag, "_diff"},   {16'd0, diff},   {16'd0, exp_d});
      check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, exp_b});
      check({tag, "_ovf"},    {31'd0, ovf},    {31'd0, exp_o});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy",   {31'd0, busy},   32'd0);
      check("rst_done",   {31'd0, done},   32'd0);
      check("rst_diff",   {16'd0, diff},   32'd0);
      check("rst_borrow", {31'd0, borrow}, 32'd0);
      check("rst_ovf",    {31'd0, ovf},    32'd0);
      rst_n = 1'b1;

      // Basic subtraction, then done must be a single-cycle pulse with held result
      run_op("s172_131", 16'd172, 16'd131, 16'd41, 1'b0, 1'b0);
      @(negedge clk);
      check("pulse_done_low", {31'd0, done}, 32'd0);
      check("pulse_diff_held", {16'd0, diff}, 32'd41);

      run_op("s400_600", 16'd400,   16'd600, 16'hFF38, 1'b1, 1'b0);
      run_op("s8000_1",  16'h8000,  16'd1,   16'h7FFF, 1'b0, 1'b1);
      run_op("s0_1",     16'd0,     16'd1,   16'hFFFF, 1'b1, 1'b0);

      // Asynchronous reset in the 7th RUN cycle
      @(negedge clk);
      a = 16'd5; b = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy",   {31'd0, busy},   32'd0);
      check("arst_done",   {31'd0, done},   32'd0);
      check("arst_diff",   {16'd0, diff},   32'd0);
      check("arst_borrow", {31'd0, borrow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", 16'd5, 16'd3, 16'd2, 1'b0, 1'b0);

      // Start held during RUN with different operands must be ignored
      @(negedge clk);
      a = 16'd1000; b = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 16'd5; b = 16'd3; start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      wait_done("ignore", 9);
      check("ignore_diff",   {16'd0, diff},   32'd999);
      check("ignore_borrow", {31'd0, borrow}, 32'd0);

      // Back-to-back: start in the done cycle, no idle bubble
      run_op("b2b_first", 16'd172, 16'd131, 16'd41, 1'b0, 1'b0);
      a = 16'd400; b = 16'd600; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy",      {31'd0, busy}, 32'd1);
      check("b2b_done_low",  {31'd0, done}, 32'd0);
      check("b2b_diff_held", {16'd0, diff}, 32'd41);
      wait_done("b2b_second", 16);
      check("b2b_diff",   {16'd0, diff},   32'hFF38);
      check("b2b_borrow", {31'd0, borrow}, 32'd1);

`ifdef SERIAL_SUB_ADD_MODE_EN
      mode = 1'b1;
      run_op("add_ffff_1", 16'hFFFF, 16'd1, 16'h0000, 1'b1, 1'b0);
      run_op("add_7fff_1", 16'h7FFF, 16'd1, 16'h8000, 1'b0, 1'b1);
      mode = 1'b0;
      run_op("sub_again",  16'd10,   16'd4, 16'd6,    1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global guard against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_subtractor_16_bit
`default_nettype wire
